// File: rtl/es5503_pkg.sv
// Shared types and helpers for the ES5503 audio path.
// Frame sums are saturated to 16 bits here.
package es5503_pkg;

  localparam int DOC_MAX_OSC = 32;
  localparam int SAMPLE_W    = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } stereo_t;

  function automatic logic signed [SAMPLE_W-1:0] sat16(
    input logic signed [31:0] x
  );
    if (x > 32'sd32767)
      return 16'sh7fff;
    else if (x < -32'sd32768)
      return 16'sh8000;
    else
      return x[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/audio_fifo.sv
// First-word fall-through FIFO for stereo frames.
// A push while full is only taken when a pop frees a slot.
module audio_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_rd;
  logic         w_wr;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) &&
                 (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_rd = pop && !empty;
  assign w_wr = push && (!full || w_rd);

  assign dout = empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + 1'b1;
      if (w_rd)
        r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/es5503_mixer.sv
// Stereo mixer behind the ES5503 DOC: sums one scan of
// oscillator samples per channel and queues saturated frames.
module es5503_mixer
  import es5503_pkg::*;
#(
  parameter int ACC_W      = 21,
  parameter int OUT_SHIFT  = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int STEREO     = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic [3:0]          in_ca,
  input  logic                in_last,
  input  logic                clr_status,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                overrun,
  output logic                frame_err,
  output logic [15:0]         frame_cnt
);

  logic signed [ACC_W-1:0] r_acc_l;
  logic signed [ACC_W-1:0] r_acc_r;
  logic [4:0]              r_slot;
  logic                    r_overrun;
  logic                    r_frame_err;
  logic [15:0]             r_frame_cnt;

  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_add_l;
  logic signed [ACC_W-1:0] w_add_r;
  logic signed [ACC_W-1:0] w_sum_l;
  logic signed [ACC_W-1:0] w_sum_r;
  logic signed [ACC_W-1:0] w_shr_l;
  logic signed [ACC_W-1:0] w_shr_r;
  logic                    w_to_l;
  logic                    w_to_r;
  logic                    w_slot_end;
  logic                    w_close;
  logic                    w_forced;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push_ok;
  logic                    w_drop;
  stereo_t                 w_res;
  logic [31:0]             w_dout;
  stereo_t                 w_head;
  logic                    w_unused_ca;

  assign w_unused_ca = &{1'b0, in_ca[3:1]};

  assign w_ext   = ACC_W'($signed(in_sample));
  assign w_to_l  = (STEREO == 0) || !in_ca[0];
  assign w_to_r  = (STEREO == 0) || in_ca[0];
  assign w_add_l = (in_valid && w_to_l) ? w_ext : '0;
  assign w_add_r = (in_valid && w_to_r) ? w_ext : '0;
  assign w_sum_l = r_acc_l + w_add_l;
  assign w_sum_r = r_acc_r + w_add_r;
  assign w_shr_l = w_sum_l >>> OUT_SHIFT;
  assign w_shr_r = w_sum_r >>> OUT_SHIFT;

  assign w_res.left  = sat16(32'(w_shr_l));
  assign w_res.right = sat16(32'(w_shr_r));

  // The 32nd slot closes the scan even when in_last never came.
  assign w_slot_end = (r_slot == 5'(DOC_MAX_OSC - 1));
  assign w_close    = in_valid && (in_last || w_slot_end);
  assign w_forced   = in_valid && !in_last && w_slot_end;

  assign w_pop     = !w_empty && out_ready;
  assign w_push_ok = w_close && (!w_full || w_pop);
  assign w_drop    = w_close && w_full && !w_pop;

  audio_fifo #(
    .W     (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_close),
    .din     (w_res),
    .pop     (w_pop),
    .dout    (w_dout),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_head    = stereo_t'(w_dout);
  assign out_valid = !w_empty;
  assign out_left  = w_head.left;
  assign out_right = w_head.right;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign frame_cnt = r_frame_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_l     <= '0;
      r_acc_r     <= '0;
      r_slot      <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (in_valid) begin
        if (w_close) begin
          r_acc_l <= '0;
          r_acc_r <= '0;
          r_slot  <= '0;
        end else begin
          r_acc_l <= w_sum_l;
          r_acc_r <= w_sum_r;
          r_slot  <= r_slot + 1'b1;
        end
      end
      if (w_push_ok)
        r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_drop)
        r_overrun <= 1'b1;
      else if (clr_status)
        r_overrun <= 1'b0;
      if (w_forced)
        r_frame_err <= 1'b1;
      else if (clr_status)
        r_frame_err <= 1'b0;
    end
  end

endmodule
